// File: rtl/uart_frame_chk_if.sv
// Bus between the bit sampler / RX FSM side (master) and the frame checker (slave).
// dbg_state mirrors the checker FSM encoding for observation.
interface uart_frame_chk_if #(
    parameter int CNT_WIDTH = 8
);
    logic                 start_evt;
    logic                 bit_valid;
    logic                 sampled_bit;
    logic                 cfg_par_en;
    logic [1:0]           cfg_par_type;
    logic                 cfg_stop2;
    logic                 err_clr;
    logic                 busy;
    logic                 frame_done;
    logic                 par_err;
    logic                 stop_err;
    logic                 par_err_sticky;
    logic                 stop_err_sticky;
    logic [CNT_WIDTH-1:0] par_err_cnt;
    logic [CNT_WIDTH-1:0] stop_err_cnt;
    logic [2:0]           dbg_state;

    modport master (
        output start_evt, bit_valid, sampled_bit, cfg_par_en, cfg_par_type, cfg_stop2, err_clr,
        input  busy, frame_done, par_err, stop_err, par_err_sticky, stop_err_sticky,
        input  par_err_cnt, stop_err_cnt, dbg_state
    );

    modport slave (
        input  start_evt, bit_valid, sampled_bit, cfg_par_en, cfg_par_type, cfg_stop2, err_clr,
        output busy, frame_done, par_err, stop_err, par_err_sticky, stop_err_sticky,
        output par_err_cnt, stop_err_cnt, dbg_state
    );
endinterface

// File: rtl/uart_frame_chk.sv
// Serial UART frame checker: accumulates data parity, checks the parity bit in four
// modes and one or two stop bits, and keeps per-frame, sticky and counted error status.
module uart_frame_chk #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input logic             clk,
    input logic             rst,
    uart_frame_chk_if.slave bus
);
    localparam int BW = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DATA   = 3'd1,
        S_PARITY = 3'd2,
        S_STOP1  = 3'd3,
        S_STOP2  = 3'd4
    } state_t;

    // Handshake: start_evt and bit_valid are single-cycle strobes with no back-pressure;
    // start_evt has priority and a bit_valid in the same cycle is dropped.

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_acc;
    logic                 w_acc_nxt;
    logic [BW-1:0]        r_cnt;
    logic [BW-1:0]        w_cnt_nxt;
    logic                 r_pe;
    logic                 w_pe_nxt;
    logic                 r_se;
    logic                 w_se_nxt;
    logic                 w_finish;
    logic                 w_par_fail;
    logic                 w_stop_fail;

    logic                 r_par_en;
    logic [1:0]           r_par_type;
    logic                 r_stop2;
    logic                 r_frame_done;
    logic                 r_par_err;
    logic                 r_stop_err;
    logic                 r_par_sticky;
    logic                 r_stop_sticky;
    logic [CNT_WIDTH-1:0] r_par_cnt;
    logic [CNT_WIDTH-1:0] r_stop_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_pe_nxt    = r_pe;
        w_se_nxt    = r_se;
        w_finish    = 1'b0;
        if (bus.start_evt) begin
            w_state_nxt = S_DATA;
            w_acc_nxt   = 1'b0;
            w_cnt_nxt   = '0;
            w_pe_nxt    = 1'b0;
            w_se_nxt    = 1'b0;
        end else if (bus.bit_valid) begin
            case (r_state)
                S_DATA: begin
                    w_acc_nxt = r_acc ^ bus.sampled_bit;
                    if (r_cnt == BW'(DATA_WIDTH - 1)) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = r_par_en ? S_PARITY : S_STOP1;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    case (r_par_type)
                        2'b00:   w_pe_nxt = r_acc ^ bus.sampled_bit;
                        2'b01:   w_pe_nxt = ~(r_acc ^ bus.sampled_bit);
                        2'b10:   w_pe_nxt = bus.sampled_bit;
                        default: w_pe_nxt = ~bus.sampled_bit;
                    endcase
                    w_state_nxt = S_STOP1;
                end
                S_STOP1: begin
                    w_se_nxt = ~bus.sampled_bit;
                    if (r_stop2) begin
                        w_state_nxt = S_STOP2;
                    end else begin
                        w_finish    = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                S_STOP2: begin
                    w_se_nxt    = r_se | ~bus.sampled_bit;
                    w_finish    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // r_pe is cleared at start, so a frame without a parity bit never reports one.
    assign w_par_fail  = w_finish & r_par_en & r_pe;
    assign w_stop_fail = w_finish & w_se_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc        <= 1'b0;
            r_cnt        <= '0;
            r_pe         <= 1'b0;
            r_se         <= 1'b0;
            r_par_en     <= 1'b0;
            r_par_type   <= 2'b00;
            r_stop2      <= 1'b0;
            r_frame_done <= 1'b0;
            r_par_err    <= 1'b0;
            r_stop_err   <= 1'b0;
        end else begin
            r_acc        <= w_acc_nxt;
            r_cnt        <= w_cnt_nxt;
            r_pe         <= w_pe_nxt;
            r_se         <= w_se_nxt;
            r_frame_done <= w_finish;
            if (bus.start_evt) begin
                r_par_en   <= bus.cfg_par_en;
                r_par_type <= bus.cfg_par_type;
                r_stop2    <= bus.cfg_stop2;
                r_par_err  <= 1'b0;
                r_stop_err <= 1'b0;
            end else if (w_finish) begin
                r_par_err  <= w_par_fail;
                r_stop_err <= w_stop_fail;
            end
        end
    end

    // A new error on the same edge as err_clr wins: flag stays set, counter restarts at 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_par_sticky  <= 1'b0;
            r_stop_sticky <= 1'b0;
            r_par_cnt     <= '0;
            r_stop_cnt    <= '0;
        end else begin
            r_par_sticky  <= (r_par_sticky & ~bus.err_clr) | w_par_fail;
            r_stop_sticky <= (r_stop_sticky & ~bus.err_clr) | w_stop_fail;
            if (bus.err_clr) begin
                r_par_cnt <= w_par_fail ? CNT_WIDTH'(1) : '0;
            end else if (w_par_fail && (r_par_cnt != '1)) begin
                r_par_cnt <= r_par_cnt + 1'b1;
            end
            if (bus.err_clr) begin
                r_stop_cnt <= w_stop_fail ? CNT_WIDTH'(1) : '0;
            end else if (w_stop_fail && (r_stop_cnt != '1)) begin
                r_stop_cnt <= r_stop_cnt + 1'b1;
            end
        end
    end

    assign bus.busy            = (r_state != S_IDLE);
    assign bus.frame_done      = r_frame_done;
    assign bus.par_err         = r_par_err;
    assign bus.stop_err        = r_stop_err;
    assign bus.par_err_sticky  = r_par_sticky;
    assign bus.stop_err_sticky = r_stop_sticky;
    assign bus.par_err_cnt     = r_par_cnt;
    assign bus.stop_err_cnt    = r_stop_cnt;
    assign bus.dbg_state       = r_state;
endmodule

// File: tb/tb_uart_frame_chk.sv
// Bench for uart_frame_chk: instance A (8 data bits, 2-bit counters) and instance B
// (5 data bits, 8-bit counters); frame results are scored against queued expectations.
module tb_uart_frame_chk;
    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    always #5 clk = ~clk;

    uart_frame_chk_if #(.CNT_WIDTH(2)) if_a ();
    uart_frame_chk_if #(.CNT_WIDTH(8)) if_b ();

    uart_frame_chk #(.DATA_WIDTH(8), .CNT_WIDTH(2)) u_a (.clk(clk), .rst(rst_a), .bus(if_a.slave));
    uart_frame_chk #(.DATA_WIDTH(5), .CNT_WIDTH(8)) u_b (.clk(clk), .rst(rst_b), .bus(if_b.slave));

    int n_checks = 0;
    int n_errors = 0;
    // Expected word: {par_err, stop_err, par_sticky, stop_sticky, par_cnt[7:0], stop_cnt[7:0]}
    logic [19:0] exp_a_q[$];
    logic [19:0] exp_b_q[$];
    logic        prev_done_a = 1'b0;
    logic        prev_done_b = 1'b0;

    function automatic void check(string nm, logic [31:0] act, logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endfunction

    function automatic logic [19:0] ex(logic pe, logic se, logic ps, logic ss, int pc, int sc);
        return {pe, se, ps, ss, 8'(pc), 8'(sc)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(int d, logic st, logic bv, logic sb, logic clr);
        if (d == 0) begin
            if_a.start_evt = st; if_a.bit_valid = bv; if_a.sampled_bit = sb; if_a.err_clr = clr;
        end else begin
            if_b.start_evt = st; if_b.bit_valid = bv; if_b.sampled_bit = sb; if_b.err_clr = clr;
        end
    endtask

    task automatic set_cfg(int d, logic pen, logic [1:0] pt, logic s2);
        if (d == 0) begin
            if_a.cfg_par_en = pen; if_a.cfg_par_type = pt; if_a.cfg_stop2 = s2;
        end else begin
            if_b.cfg_par_en = pen; if_b.cfg_par_type = pt; if_b.cfg_stop2 = s2;
        end
    endtask

    function automatic logic busy_of(int d);
        return (d == 0) ? if_a.busy : if_b.busy;
    endfunction

    // Config is scrambled right after start to show only the start-cycle values matter.
    task automatic start_frame(int d, logic pen, logic [1:0] pt, logic s2, logic bv);
        set_cfg(d, pen, pt, s2);
        set_in(d, 1'b1, bv, 1'b1, 1'b0);
        tick();
        set_in(d, 1'b0, 1'b0, 1'b0, 1'b0);
        set_cfg(d, ~pen, ~pt, ~s2);
        check($sformatf("busy_start_%0d", d), 32'(busy_of(d)), 32'd1);
    endtask

    task automatic strobe(int d, logic b, logic clr);
        repeat ($urandom_range(0, 1)) tick();
        set_in(d, 1'b0, 1'b1, b, clr);
        tick();
        set_in(d, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic frame(int d, int nbits, logic [8:0] data, logic pen, logic [1:0] pt,
                         logic s2, logic pbit, logic st1, logic st2, logic clr_last,
                         logic bv_at_start, logic [19:0] exp);
        if (d == 0) exp_a_q.push_back(exp);
        else        exp_b_q.push_back(exp);
        start_frame(d, pen, pt, s2, bv_at_start);
        for (int i = 0; i < nbits; i++) strobe(d, data[i], 1'b0);
        if (pen) strobe(d, pbit, 1'b0);
        strobe(d, st1, clr_last && !s2);
        if (s2) strobe(d, st2, clr_last);
        check($sformatf("busy_end_%0d", d), 32'(busy_of(d)), 32'd0);
    endtask

    always @(negedge clk) begin
        if (if_a.frame_done) begin
            check("a_done_pulse", 32'(prev_done_a), 32'd0);
            if (exp_a_q.size() == 0) begin
                check("a_unexpected_done", 32'd1, 32'd0);
            end else begin
                check("a_frame", 32'({if_a.par_err, if_a.stop_err, if_a.par_err_sticky,
                      if_a.stop_err_sticky, 6'd0, if_a.par_err_cnt, 6'd0, if_a.stop_err_cnt}),
                      32'(exp_a_q.pop_front()));
            end
        end
        prev_done_a <= if_a.frame_done;
    end

    always @(negedge clk) begin
        if (if_b.frame_done) begin
            check("b_done_pulse", 32'(prev_done_b), 32'd0);
            if (exp_b_q.size() == 0) begin
                check("b_unexpected_done", 32'd1, 32'd0);
            end else begin
                check("b_frame", 32'({if_b.par_err, if_b.stop_err, if_b.par_err_sticky,
                      if_b.stop_err_sticky, if_b.par_err_cnt, if_b.stop_err_cnt}),
                      32'(exp_b_q.pop_front()));
            end
        end
        prev_done_b <= if_b.frame_done;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_a = 1'b0;
        rst_b = 1'b0;
        set_in(0, 0, 0, 0, 0);
        set_in(1, 0, 0, 0, 0);
        set_cfg(0, 0, 2'b00, 0);
        set_cfg(1, 0, 2'b00, 0);
        repeat (3) tick();
        rst_a = 1'b1;
        rst_b = 1'b1;
        tick();
        check("a_reset", 32'({if_a.busy, if_a.frame_done, if_a.par_err, if_a.stop_err,
              if_a.par_err_sticky, if_a.stop_err_sticky, if_a.par_err_cnt, if_a.stop_err_cnt}), 32'd0);
        check("b_reset", 32'({if_b.busy, if_b.frame_done, if_b.par_err, if_b.stop_err,
              if_b.par_err_sticky, if_b.stop_err_sticky, if_b.par_err_cnt, if_b.stop_err_cnt}), 32'd0);

        // Strobes in IDLE are ignored.
        strobe(0, 1'b1, 1'b0);
        strobe(0, 1'b0, 1'b0);
        check("a_idle_busy", 32'(if_a.busy), 32'd0);

        // Instance A: 8 data bits, 2-bit counters.
        frame(0, 8, 9'h0A5, 1, 2'b00, 0, 0, 1, 1, 0, 0, ex(0, 0, 0, 0, 0, 0));
        frame(0, 8, 9'h0A5, 1, 2'b00, 0, 1, 1, 1, 0, 0, ex(1, 0, 1, 0, 1, 0));
        frame(0, 8, 9'h0A5, 1, 2'b01, 0, 1, 1, 1, 0, 0, ex(0, 0, 1, 0, 1, 0));
        frame(0, 8, 9'h000, 1, 2'b11, 1, 1, 1, 0, 0, 0, ex(0, 1, 1, 1, 1, 1));
        frame(0, 8, 9'h000, 1, 2'b10, 0, 1, 1, 1, 0, 0, ex(1, 0, 1, 1, 2, 1));

        // Aborted frame: restart after 4 data bits.
        start_frame(0, 1, 2'b00, 0, 0);
        for (int i = 0; i < 4; i++) strobe(0, i[0], 1'b0);
        frame(0, 8, 9'h0A5, 1, 2'b00, 0, 0, 1, 1, 0, 0, ex(0, 0, 1, 1, 2, 1));

        set_in(0, 0, 0, 0, 1);
        tick();
        set_in(0, 0, 0, 0, 0);
        check("a_clr_sticky", 32'({if_a.par_err_sticky, if_a.stop_err_sticky}), 32'd0);
        check("a_clr_cnt", 32'({if_a.par_err_cnt, if_a.stop_err_cnt}), 32'd0);

        frame(0, 8, 9'h0A5, 1, 2'b00, 0, 1, 1, 1, 0, 0, ex(1, 0, 1, 0, 1, 0));
        frame(0, 8, 9'h0A5, 1, 2'b00, 0, 1, 1, 1, 0, 0, ex(1, 0, 1, 0, 2, 0));
        frame(0, 8, 9'h0A5, 1, 2'b00, 0, 1, 1, 1, 0, 0, ex(1, 0, 1, 0, 3, 0));
        frame(0, 8, 9'h0A5, 1, 2'b00, 0, 1, 1, 1, 0, 0, ex(1, 0, 1, 0, 3, 0));
        frame(0, 8, 9'h0A5, 1, 2'b00, 0, 1, 1, 1, 0, 0, ex(1, 0, 1, 0, 3, 0));
        frame(0, 8, 9'h0A5, 1, 2'b00, 0, 1, 1, 1, 1, 0, ex(1, 0, 1, 0, 1, 0));
        // start_evt with a simultaneous bit_valid: the bit must not be consumed.
        frame(0, 8, 9'h0A5, 1, 2'b00, 0, 0, 1, 1, 0, 1, ex(0, 0, 1, 0, 1, 0));

        // Instance B: 5 data bits, no parity.
        frame(1, 5, 9'h016, 0, 2'b00, 0, 0, 1, 1, 0, 0, ex(0, 0, 0, 0, 0, 0));
        frame(1, 5, 9'h001, 0, 2'b00, 0, 0, 0, 1, 0, 0, ex(0, 1, 0, 1, 0, 1));

        start_frame(1, 0, 2'b00, 0, 0);
        strobe(1, 1'b1, 1'b0);
        strobe(1, 1'b0, 1'b0);
        rst_b = 1'b0;
        #1;
        check("b_rst_busy", 32'(if_b.busy), 32'd0);
        check("b_rst_outs", 32'({if_b.frame_done, if_b.par_err, if_b.stop_err,
              if_b.par_err_sticky, if_b.stop_err_sticky}), 32'd0);
        check("b_rst_cnt", 32'({if_b.par_err_cnt, if_b.stop_err_cnt}), 32'd0);
        tick();
        rst_b = 1'b1;
        tick();
        frame(1, 5, 9'h01F, 0, 2'b00, 1, 0, 1, 1, 0, 0, ex(0, 0, 0, 0, 0, 0));

        repeat (4) tick();
        check("a_queue_empty", 32'(exp_a_q.size()), 32'd0);
        check("b_queue_empty", 32'(exp_b_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
